div_share_arb: RTL and testbench
================================

# div_share_arb

Round-robin arbiter and sequencer that shares one iterative `divider` instance among `NUM_REQ` requesters. Each requester presents operands through a valid/ready handshake. The arbiter grants one requester at a time, launches the shared divider, waits for its result, and returns quotient, remainder and error to the granted requester. It sits between the compute clients and the single divider in the datapath.

## Interface
- `WIDTH`, 32, operand and result width; matches the divider's `WIDTH`
- `NUM_REQ`, 4, number of requesters; range 2..16
- `clk_in`  input  1  system clock
- `rst_n_in`  input  1  reset, asynchronous, active-low
- `req_valid_in`  input  `NUM_REQ`  per-requester operand valid
- `req_dividend_in`  input  `NUM_REQ*WIDTH`  dividends; requester i occupies bits `[i*WIDTH +: WIDTH]`
- `req_divisor_in`  input  `NUM_REQ*WIDTH`  divisors, packed the same way
- `req_ready_out`  output  `NUM_REQ`  per-requester accept; at most one bit set
- `resp_valid_out`  output  `NUM_REQ`  one-cycle, one-hot result strobe to the owning requester
- `resp_quotient_out`  output  `WIDTH`  result quotient, shared by all requesters
- `resp_remainder_out`  output  `WIDTH`  result remainder, shared
- `resp_error_out`  output  1  result error flag, shared
- `div_dividend_out`, `div_divisor_out`  output  `WIDTH`  operands to the divider
- `div_data_valid_out`  output  1  one-cycle start pulse to the divider
- `div_quotient_in`, `div_remainder_in`  input  `WIDTH`  divider results
- `div_data_valid_in`  input  1  divider done pulse
- `div_error_in`  input  1  divider error flag
- `div_busy_in`  input  1  divider busy

## Operation
- State machine has four states: IDLE, ISSUE, WAIT, RESPOND. Reset enters IDLE.
- **IDLE**
  - Grant is the first i with `req_valid_in[i]`=1, searching from `ptr`, `ptr+1`, … with wrap mod `NUM_REQ`.
  - `req_ready_out[grant]`=1 (combinational) only if some valid bit is set and `div_busy_in`=0.
  - On handshake: register operands, register `owner`=grant, set `ptr` <= (grant+1) mod `NUM_REQ`, then go to ISSUE.
- **ISSUE**
  - `div_data_valid_out`=1 for exactly one cycle, with registered operands on `div_*_out`.
  - Then go to WAIT.
- **WAIT**
  - Hold operands until `div_data_valid_in`=1.
  - Then capture `div_quotient_in`, `div_remainder_in` and `div_error_in`, and go to RESPOND.
- **RESPOND**
  - `resp_valid_out[owner]`=1 for one cycle, with the registered result on the `resp_*` outputs.
  - Return to IDLE.
- Requesters have no backpressure on responses. A requester that raised valid must accept the `resp_valid_out` strobe.
- `div_data_valid_in` outside WAIT is ignored and has no state effect.
- Requesters must hold operands and valid until ready. Operands sampled at handshake are the only ones used.
- `req_valid_in` deasserted without handshake is legal and is not an error.

## Timing
- Reset (async assert, sync-safe deassert):
  - all outputs 0, state IDLE, `ptr`=0, `owner`=0
  - result and operand registers 0
- Handshake at cycle T:
  - `div_data_valid_out` at T+1
  - divider done at T+1+D, where D is divider latency (33 cycles for `WIDTH`=32)
  - `resp_valid_out` at T+2+D
  - earliest next handshake at T+3+D
- `req_ready_out` is never asserted outside IDLE.
- Reset asserted mid-operation aborts the transaction and emits no response. The divider is reset by the same system reset.
- Simultaneous requests are served in strict round-robin order, so each requester waits at most `NUM_REQ-1` transactions.

## Configuration
- Macro: `DIV_SHARE_ARB_ZERO_CHECK_EN`
- Defined:
  - At handshake, a divisor of 0 goes IDLE→RESPOND directly; the divider is not launched.
  - Response: quotient = all ones, remainder = dividend, error = 1.
  - `resp_valid_out` appears at T+1.
- Undefined:
  - A zero divisor is forwarded to the divider like any other divisor.
  - The response carries whatever the divider returns (`div_error_in` passed through).

## Test plan
- Single request, requester 2 only: 100/7 → one handshake, one start pulse, `resp_valid_out`=4'b0100, quotient 14, remainder 2, error 0, at T+2+D.
- All four valid from reset: 4 transactions in order 0,1,2,3, with `ptr` wrap verified. Requester 0 requests again and is granted only after requester 3.
- Requester 1 re-requests continuously while requester 3 also requests: grants alternate 1,3,1,3 with no starvation.
- `div_busy_in` forced 1 in IDLE with requests pending: no `req_ready_out` asserted until it falls.
- Divisor 0, dividend 55, macro defined → response at T+1, quotient 0xFFFFFFFF, remainder 55, error 1, no `div_data_valid_out`. Macro undefined → divider is launched and its outputs are passed through.
- `rst_n_in` pulled low during WAIT: all outputs 0 immediately. After release, a new request completes normally and no stale response is emitted.

Source files
------------

// File: rtl/div_share_arb.sv
// div_share_arb: round-robin arbiter that shares one iterative divider among
// NUM_REQ requesters, then returns the result to the requester that was granted.
//
// Ports:
//   clk_in, rst_n_in                      clock, async active-low reset
//   req_valid_in / req_ready_out          per-requester operand handshake
//   req_dividend_in / req_divisor_in      packed operands, requester i at [i*WIDTH +: WIDTH]
//   resp_valid_out                        one-cycle one-hot result strobe
//   resp_quotient/remainder/error_out     shared result bus
//   div_dividend/divisor_out              operands to the shared divider
//   div_data_valid_out                    one-cycle divider start pulse
//   div_quotient/remainder_in, div_error_in, div_data_valid_in, div_busy_in
//                                         divider results and status
//
// Optional feature macro: DIV_SHARE_ARB_ZERO_CHECK_EN
//   When defined, a zero divisor is answered locally (quotient all ones,
//   remainder = dividend, error = 1) one cycle after the handshake, and the
//   divider is not launched.

`timescale 1ns/1ps

module div_share_arb #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned NUM_REQ = 4
) (
    input  logic                     clk_in,
    input  logic                     rst_n_in,
    input  logic [NUM_REQ-1:0]       req_valid_in,
    input  logic [NUM_REQ*WIDTH-1:0] req_dividend_in,
    input  logic [NUM_REQ*WIDTH-1:0] req_divisor_in,
    output logic [NUM_REQ-1:0]       req_ready_out,
    output logic [NUM_REQ-1:0]       resp_valid_out,
    output logic [WIDTH-1:0]         resp_quotient_out,
    output logic [WIDTH-1:0]         resp_remainder_out,
    output logic                     resp_error_out,
    output logic [WIDTH-1:0]         div_dividend_out,
    output logic [WIDTH-1:0]         div_divisor_out,
    output logic                     div_data_valid_out,
    input  logic [WIDTH-1:0]         div_quotient_in,
    input  logic [WIDTH-1:0]         div_remainder_in,
    input  logic                     div_data_valid_in,
    input  logic                     div_error_in,
    input  logic                     div_busy_in
);

    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESPOND} state_t;

    state_t               state_q, state_d;
    logic [PTR_W-1:0]     ptr_q, owner_q, owner_d, grant_c, ptr_next_c;
    logic                 any_valid_c, hs_c, zero_div_c;
    logic [WIDTH-1:0]     sel_dvd_c, sel_dvs_c;
    logic [WIDTH-1:0]     dvd_q, dvs_q, quo_q, rem_q;
    logic                 err_q, start_q;
    logic [NUM_REQ-1:0]   resp_valid_q, ready_c;

    // Round-robin search starting at ptr_q, plus operand mux for the winner.
    always_comb begin
        int unsigned idx;
        grant_c     = ptr_q;
        any_valid_c = 1'b0;
        sel_dvd_c   = '0;
        sel_dvs_c   = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = 32'(ptr_q) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!any_valid_c && req_valid_in[PTR_W'(idx)]) begin
                any_valid_c = 1'b1;
                grant_c     = PTR_W'(idx);
            end
        end
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (PTR_W'(i) == grant_c) begin
                sel_dvd_c = req_dividend_in[i*WIDTH +: WIDTH];
                sel_dvs_c = req_divisor_in[i*WIDTH +: WIDTH];
            end
        end
    end

    // Ready is gated by reset so every output reads 0 while rst_n_in is low.
    always_comb begin
        hs_c       = (state_q == IDLE) && any_valid_c && !div_busy_in && rst_n_in;
        ready_c    = hs_c ? (NUM_REQ'(1) << grant_c) : '0;
        ptr_next_c = (grant_c == PTR_W'(NUM_REQ - 1)) ? '0 : grant_c + PTR_W'(1);
        owner_d    = hs_c ? grant_c : owner_q;
`ifdef DIV_SHARE_ARB_ZERO_CHECK_EN
        zero_div_c = hs_c && (sel_dvs_c == '0);
`else
        zero_div_c = 1'b0;
`endif
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (hs_c) state_d = zero_div_c ? RESPOND : ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    if (div_data_valid_in) state_d = RESPOND;
            RESPOND: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, pointer, operand/result registers and registered strobes.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            owner_q      <= '0;
            dvd_q        <= '0;
            dvs_q        <= '0;
            quo_q        <= '0;
            rem_q        <= '0;
            err_q        <= 1'b0;
            start_q      <= 1'b0;
            resp_valid_q <= '0;
        end else begin
            state_q      <= state_d;
            start_q      <= (state_d == ISSUE);
            resp_valid_q <= (state_d == RESPOND) ? (NUM_REQ'(1) << owner_d) : '0;
            owner_q      <= owner_d;
            if (hs_c) begin
                dvd_q <= sel_dvd_c;
                dvs_q <= sel_dvs_c;
                ptr_q <= ptr_next_c;
            end
            if (zero_div_c) begin
                quo_q <= '1;
                rem_q <= sel_dvd_c;
                err_q <= 1'b1;
            end else if (state_q == WAIT && div_data_valid_in) begin
                quo_q <= div_quotient_in;
                rem_q <= div_remainder_in;
                err_q <= div_error_in;
            end
        end
    end

    assign req_ready_out      = ready_c;
    assign resp_valid_out     = resp_valid_q;
    assign resp_quotient_out  = quo_q;
    assign resp_remainder_out = rem_q;
    assign resp_error_out     = err_q;
    assign div_dividend_out   = dvd_q;
    assign div_divisor_out    = dvs_q;
    assign div_data_valid_out = start_q;

endmodule

// File: tb/tb_div_share_arb.sv
// Directed bench for div_share_arb with a behavioural 33-cycle divider model.
`timescale 1ns/1ps

module tb_div_share_arb;

    localparam int D = 33;

    logic         clk_in, rst_n_in;
    logic [3:0]   req_valid, req_ready, resp_valid;
    logic [127:0] req_dividend, req_divisor;
    logic [31:0]  resp_q, resp_r, div_dvd, div_dvs, div_q, div_r;
    logic         resp_e, div_start, div_done, div_err, div_busy;

    logic [31:0]  dvd [4];
    logic [31:0]  dvs [4];
    int           pend [4];
    logic         model_busy, force_busy;
    logic [31:0]  ma, mb;
    int           done_at, cyc, checks, failures, viol;

    int           hs_cyc[$], hs_id[$], st_cyc[$], rs_cyc[$];
    logic [3:0]   rs_vec[$];
    logic [31:0]  rs_q[$], rs_r[$];
    logic         rs_e[$];

    assign req_dividend = {dvd[3], dvd[2], dvd[1], dvd[0]};
    assign req_divisor  = {dvs[3], dvs[2], dvs[1], dvs[0]};
    assign div_busy     = model_busy | force_busy;

    div_share_arb #(.WIDTH(32), .NUM_REQ(4)) dut (
        .clk_in             (clk_in),
        .rst_n_in           (rst_n_in),
        .req_valid_in       (req_valid),
        .req_dividend_in    (req_dividend),
        .req_divisor_in     (req_divisor),
        .req_ready_out      (req_ready),
        .resp_valid_out     (resp_valid),
        .resp_quotient_out  (resp_q),
        .resp_remainder_out (resp_r),
        .resp_error_out     (resp_e),
        .div_dividend_out   (div_dvd),
        .div_divisor_out    (div_dvs),
        .div_data_valid_out (div_start),
        .div_quotient_in    (div_q),
        .div_remainder_in   (div_r),
        .div_data_valid_in  (div_done),
        .div_error_in       (div_err),
        .div_busy_in        (div_busy)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic sync_valid();
        for (int i = 0; i < 4; i++) req_valid[i] = (pend[i] > 0);
        #1;
    endtask

    task automatic clear_logs();
        hs_cyc.delete(); hs_id.delete(); st_cyc.delete(); rs_cyc.delete();
        rs_vec.delete(); rs_q.delete(); rs_r.delete(); rs_e.delete();
    endtask

    // One clock: log handshakes, start pulses and responses; drive divider model.
    task automatic tick();
        logic [3:0] hs;
        hs = req_ready & req_valid;
        @(posedge clk_in);
        cyc++;
        for (int i = 0; i < 4; i++) begin
            if (hs[i]) begin
                hs_cyc.push_back(cyc - 1);
                hs_id.push_back(i);
                if (pend[i] > 0) pend[i]--;
            end
        end
        #1;
        if (div_start) begin
            st_cyc.push_back(cyc);
            ma = div_dvd; mb = div_dvs;
            done_at = cyc + D;
            model_busy = 1'b1;
        end
        if (resp_valid != 4'b0) begin
            rs_cyc.push_back(cyc); rs_vec.push_back(resp_valid);
            rs_q.push_back(resp_q); rs_r.push_back(resp_r); rs_e.push_back(resp_e);
        end
        if (cyc == done_at) begin
            div_done   = 1'b1;
            div_q      = (mb == 0) ? 32'hFFFF_FFFF : ma / mb;
            div_r      = (mb == 0) ? ma : ma % mb;
            div_err    = (mb == 0);
            model_busy = 1'b0;
        end else begin
            div_done = 1'b0;
        end
        sync_valid();
        if ($countones(req_ready) > 1) viol++;
    endtask

    task automatic do_reset();
        rst_n_in = 1'b0;
        for (int i = 0; i < 4; i++) pend[i] = 0;
        req_valid = 4'b0; model_busy = 1'b0; force_busy = 1'b0;
        div_done = 1'b0; done_at = -1;
        clear_logs();
        repeat (2) @(posedge clk_in);
        #1 rst_n_in = 1'b1;
        #1;
    endtask

    task automatic wait_resps(input int n, input int limit);
        int k;
        k = 0;
        while (rs_cyc.size() < n && k < limit) begin
            tick();
            k++;
        end
        chk("resp_count", 64'(rs_cyc.size()), 64'(n));
    endtask

    int          exp_id[5];
    logic [31:0] exp_q[4], exp_r[4];

    initial begin
        checks = 0; failures = 0; viol = 0; cyc = 0; done_at = -1;
        rst_n_in = 1'b0; force_busy = 1'b0; model_busy = 1'b0;
        div_done = 1'b0; div_q = '0; div_r = '0; div_err = 1'b0;
        for (int i = 0; i < 4; i++) begin dvd[i] = 32'd1; dvs[i] = 32'd1; pend[i] = 0; end
        req_valid = 4'hF;
        #12;
        // Reset values, with every requester valid.
        chk("rst_ready",  64'(req_ready), 64'(0));
        chk("rst_resp_v", 64'(resp_valid), 64'(0));
        chk("rst_result", {31'b0, resp_e, resp_q}, 64'(0));
        chk("rst_div_op", {div_dvd, div_dvs}, 64'(0));
        chk("rst_start",  64'(div_start), 64'(0));

        // Single request on requester 2: 100/7.
        do_reset();
        dvd[2] = 32'd100; dvs[2] = 32'd7; pend[2] = 1;
        sync_valid();
        wait_resps(1, 60);
        chk("t1_grant",  64'(hs_id[0]), 64'(2));
        chk("t1_starts", 64'(st_cyc.size()), 64'(1));
        chk("t1_st_lat", 64'(st_cyc[0] - hs_cyc[0]), 64'(1));
        chk("t1_rs_lat", 64'(rs_cyc[0] - hs_cyc[0]), 64'(D + 2));
        chk("t1_vec",    64'(rs_vec[0]), 64'(4'b0100));
        chk("t1_quo",    64'(rs_q[0]), 64'(14));
        chk("t1_rem",    64'(rs_r[0]), 64'(2));
        chk("t1_err",    64'(rs_e[0]), 64'(0));
        repeat (5) tick();
        chk("t1_single", 64'(rs_cyc.size()), 64'(1));

        // All four valid from reset; requester 0 asks twice.
        do_reset();
        dvd[0] = 32'd50; dvs[0] = 32'd5;  exp_q[0] = 32'd10;         exp_r[0] = 32'd0;
        dvd[1] = 32'd17; dvs[1] = 32'd4;  exp_q[1] = 32'd4;          exp_r[1] = 32'd1;
        dvd[2] = 32'd9;  dvs[2] = 32'd10; exp_q[2] = 32'd0;          exp_r[2] = 32'd9;
        dvd[3] = 32'hFFFF_FFFF; dvs[3] = 32'd16; exp_q[3] = 32'h0FFF_FFFF; exp_r[3] = 32'd15;
        pend[0] = 2; pend[1] = 1; pend[2] = 1; pend[3] = 1;
        exp_id = '{0, 1, 2, 3, 0};
        sync_valid();
        wait_resps(5, 5 * (D + 3) + 20);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("t2_id%0d", k),  64'(hs_id[k]), 64'(exp_id[k]));
            chk($sformatf("t2_vec%0d", k), 64'(rs_vec[k]), 64'(4'b0001 << exp_id[k]));
            chk($sformatf("t2_quo%0d", k), 64'(rs_q[k]), 64'(exp_q[exp_id[k]]));
            chk($sformatf("t2_rem%0d", k), 64'(rs_r[k]), 64'(exp_r[exp_id[k]]));
        end
        chk("t2_spacing", 64'(hs_cyc[1] - hs_cyc[0]), 64'(D + 3));

        // Requester 1 keeps asking while requester 3 also asks.
        do_reset();
        dvd[1] = 32'd7;  dvs[1] = 32'd2; pend[1] = 3;
        dvd[3] = 32'd20; dvs[3] = 32'd6; pend[3] = 2;
        exp_id = '{1, 3, 1, 3, 1};
        sync_valid();
        wait_resps(5, 5 * (D + 3) + 20);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("t3_id%0d", k),  64'(hs_id[k]), 64'(exp_id[k]));
            chk($sformatf("t3_rem%0d", k), 64'(rs_r[k]), 64'((exp_id[k] == 1) ? 1 : 2));
        end

        // Divider busy blocks every grant until it drops.
        do_reset();
        force_busy = 1'b1;
        dvd[0] = 32'd81; dvs[0] = 32'd9; pend[0] = 1;
        sync_valid();
        repeat (10) tick();
        chk("t4_ready_busy", 64'(req_ready), 64'(0));
        chk("t4_no_hs",      64'(hs_cyc.size()), 64'(0));
        force_busy = 1'b0;
        #1;
        wait_resps(1, 60);
        chk("t4_grant", 64'(hs_id[0]), 64'(0));
        chk("t4_quo",   64'(rs_q[0]), 64'(9));

        // Zero divisor.
        do_reset();
        dvd[2] = 32'd55; dvs[2] = 32'd0; pend[2] = 1;
        sync_valid();
        wait_resps(1, 60);
`ifdef DIV_SHARE_ARB_ZERO_CHECK_EN
        chk("t5_starts", 64'(st_cyc.size()), 64'(0));
        chk("t5_rs_lat", 64'(rs_cyc[0] - hs_cyc[0]), 64'(1));
`else
        chk("t5_starts", 64'(st_cyc.size()), 64'(1));
        chk("t5_rs_lat", 64'(rs_cyc[0] - hs_cyc[0]), 64'(D + 2));
`endif
        chk("t5_vec", 64'(rs_vec[0]), 64'(4'b0100));
        chk("t5_quo", 64'(rs_q[0]), 64'(32'hFFFF_FFFF));
        chk("t5_rem", 64'(rs_r[0]), 64'(55));
        chk("t5_err", 64'(rs_e[0]), 64'(1));

        // Reset pulled during WAIT aborts without a response.
        do_reset();
        dvd[1] = 32'd12; dvs[1] = 32'd5; pend[1] = 1;
        sync_valid();
        for (int k = 0; k < 10 && st_cyc.size() == 0; k++) tick();
        repeat (5) tick();
        chk("t6_in_wait", 64'(div_dvd), 64'(12));
        dvd[1] = 32'd30; dvs[1] = 32'd4; pend[1] = 1;
        req_valid = 4'b0010;
        rst_n_in = 1'b0;
        #1;
        chk("t6_rst_ready", 64'(req_ready), 64'(0));
        chk("t6_rst_op",    {div_dvd, div_dvs}, 64'(0));
        chk("t6_rst_strb",  64'({resp_valid, div_start}), 64'(0));
        done_at = -1; model_busy = 1'b0; div_done = 1'b0;
        clear_logs();
        repeat (2) @(posedge clk_in);
        #1 rst_n_in = 1'b1;
        #1;
        wait_resps(1, 60);
        chk("t6_quo",    64'(rs_q[0]), 64'(7));
        chk("t6_rem",    64'(rs_r[0]), 64'(2));
        chk("t6_rs_lat", 64'(rs_cyc[0] - hs_cyc[0]), 64'(D + 2));
        repeat (40) tick();
        chk("t6_no_stale", 64'(rs_cyc.size()), 64'(1));

        chk("ready_onehot", 64'(viol), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
